// File: rtl/div_ratio_ctrl.sv
// div_ratio_ctrl: run-time controller for the divided-clock path.
// Owns the half-period count H of the divided output clock_p, sequences
// start/stop so clock_p never produces a runt pulse, and accepts new H values
// over a valid/ready handshake, applying them only at full-period boundaries.
//
// Ports:
//   clock      in   system clock, all logic on posedge
//   reset      in   asynchronous active-low reset
//   enable     in   1 = run the divider, 0 = stop at the next safe point
//   cfg_valid  in   new half-period offered
//   cfg_half   in   offered half-period in clock cycles (0 is rejected)
//   cfg_ready  out  1 = able to accept cfg_half
//   clock_p    out  divided square wave, period 2*H
//   tick       out  one-cycle pulse in the cycle clock_p goes 0->1
//   busy       out  1 when the FSM is not idle
//   cfg_err    out  one-cycle pulse: a zero half-period was rejected
module div_ratio_ctrl #(
  parameter int unsigned       CNT_W        = 24,
  parameter logic [CNT_W-1:0]  DEFAULT_HALF = CNT_W'(12500000)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clock_p,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_p_q, clk_p_d;
  logic             tick_q, tick_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // Shared decode used by both the next-state and datapath logic.
  logic at_end;
  logic stop_now;
  logic adv;
  logic fall;
  logic xfer;

  // H is never 0, so H-1 cannot wrap.
  assign at_end   = (cnt_q == (half_q - CNT_W'(1)));
  // Low phase with enable dropped: stop without waiting for a boundary.
  assign stop_now = (state_q == S_RUN) && !enable && !clk_p_q;
  assign adv      = (state_q != S_IDLE) && !stop_now;
  assign fall     = adv && at_end && clk_p_q;
  assign xfer     = cfg_valid && ready_q;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (!enable) begin
          // High phase must complete; if it ends this cycle we are already safe.
          if (!clk_p_q || at_end) state_d = S_IDLE;
          else                    state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (enable)      state_d = S_RUN;
        else if (at_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d    = '0;
    clk_p_d  = clk_p_q;
    tick_d   = 1'b0;
    half_d   = half_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ready_d  = ready_q;
    err_d    = 1'b0;
    busy_d   = (state_d != S_IDLE);

    if (adv) begin
      if (at_end) begin
        cnt_d   = '0;
        clk_p_d = !clk_p_q;
        tick_d  = !clk_p_q;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end else if (state_q == S_IDLE) begin
      clk_p_d = 1'b0;
    end

    // Apply a pending ratio only at a period boundary or while idle.
    if (pend_v_q && (fall || (state_q == S_IDLE))) begin
      half_d   = pend_q;
      pend_v_d = 1'b0;
      ready_d  = 1'b1;
    end

    // Handshake: ready implies nothing pending, so this never races the apply.
    if (xfer) begin
      if (cfg_half == '0) begin
        err_d = 1'b1;
      end else begin
        pend_d   = cfg_half;
        pend_v_d = 1'b1;
        ready_d  = 1'b0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      half_q   <= DEFAULT_HALF;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      clk_p_q  <= 1'b0;
      tick_q   <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      clk_p_q  <= clk_p_d;
      tick_q   <= tick_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign cfg_ready = ready_q;
  assign clock_p   = clk_p_q;
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Testbench for div_ratio_ctrl with a 5-cycle default half-period.
module tb_div_ratio_ctrl;

  localparam int unsigned CNT_W = 24;
  localparam int unsigned NVEC  = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic             cfg_ready;
  logic             clock_p;
  logic             tick;
  logic             busy;
  logic             cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  div_ratio_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_HALF(24'd5)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_half (cfg_half),
    .cfg_ready(cfg_ready),
    .clock_p  (clock_p),
    .tick     (tick),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             en;
    logic             v;
    logic [CNT_W-1:0] h;
    logic             cp;
    logic             tk;
    logic             bz;
    logic             rdy;
    logic             err;
  } vec_t;

  vec_t tv [NVEC];

  function automatic vec_t mk(input logic en, input logic v, input logic [CNT_W-1:0] h,
                              input logic cp, input logic tk, input logic bz,
                              input logic rdy, input logic err);
    vec_t r;
    r.en = en; r.v = v; r.h = h; r.cp = cp; r.tk = tk; r.bz = bz; r.rdy = rdy; r.err = err;
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Count consecutive samples at level lvl, starting with the current one.
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (clock_p === lvl && n < 64) begin
      n++;
      step();
    end
  endtask

  task automatic wait_level(input string nm, input logic lvl);
    int k;
    k = 0;
    while (clock_p !== lvl && k < 64) begin
      step();
      k++;
    end
    chk(nm, 32'(clock_p), 32'(lvl));
  endtask

  initial begin
    int n;

    // en, v, h, | cp, tk, bz, rdy, err  (outputs sampled after the edge)
    tv[0]  = mk(1, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i < 5; i++) tv[i] = mk(1, 0, 0, 0, 0, 1, 1, 0);
    tv[5]  = mk(1, 0, 0, 1, 1, 1, 1, 0);
    for (int i = 6; i < 10; i++) tv[i] = mk(1, 0, 0, 1, 0, 1, 1, 0);
    for (int i = 10; i < 15; i++) tv[i] = mk(1, 0, 0, 0, 0, 1, 1, 0);
    tv[15] = mk(1, 0, 0, 1, 1, 1, 1, 0);
    tv[16] = mk(1, 1, 0, 1, 0, 1, 1, 1);   // zero half-period rejected
    for (int i = 17; i < 20; i++) tv[i] = mk(1, 0, 0, 1, 0, 1, 1, 0);
    for (int i = 20; i < 25; i++) tv[i] = mk(1, 0, 0, 0, 0, 1, 1, 0);
    tv[25] = mk(1, 0, 0, 1, 1, 1, 1, 0);
    for (int i = 26; i < 30; i++) tv[i] = mk(0, 0, 0, 1, 0, 1, 1, 0);  // drain
    tv[30] = mk(0, 0, 0, 0, 0, 0, 1, 0);
    tv[31] = mk(0, 0, 0, 0, 0, 0, 1, 0);

    // Reset values while reset is held.
    #12;
    chk("rst_clock_p", 32'(clock_p), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Vector table: steady run, zero cfg, drain to idle.
    for (int i = 0; i < int'(NVEC); i++) begin
      enable    = tv[i].en;
      cfg_valid = tv[i].v;
      cfg_half  = tv[i].h;
      step();
      chk($sformatf("v%0d_clock_p", i), 32'(clock_p), 32'(tv[i].cp));
      chk($sformatf("v%0d_tick", i), 32'(tick), 32'(tv[i].tk));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].bz));
      chk($sformatf("v%0d_cfg_ready", i), 32'(cfg_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d_cfg_err", i), 32'(cfg_err), 32'(tv[i].err));
    end
    cfg_valid = 1'b0;

    // New ratio offered mid-high: current period finishes at 5/5, then 3/3.
    enable = 1'b1;
    wait_level("t3_rise", 1'b1);
    cfg_valid = 1'b1;
    cfg_half  = 24'd3;
    step();
    cfg_valid = 1'b0;
    chk("t3_ready_low", 32'(cfg_ready), 0);
    n = 2;
    while (clock_p === 1'b1 && n < 64) begin
      chk("t3_ready_held", 32'(cfg_ready), 0);
      step();
      if (clock_p === 1'b1) n++;
    end
    chk("t3_old_high", 32'(n), 5);
    chk("t3_ready_back", 32'(cfg_ready), 1);
    run_len(1'b0, n);
    chk("t3_new_low", 32'(n), 3);
    run_len(1'b1, n);
    chk("t3_new_high", 32'(n), 3);
    run_len(1'b0, n);
    chk("t3_new_low2", 32'(n), 3);

    // Re-raise enable during drain: no disturbance, busy stays high.
    enable = 1'b0;
    step();
    chk("t5_drain_cp", 32'(clock_p), 1);
    chk("t5_drain_busy", 32'(busy), 1);
    enable = 1'b1;
    step();
    chk("t5_rerun_cp", 32'(clock_p), 1);
    chk("t5_rerun_busy", 32'(busy), 1);
    step();
    chk("t5_fall_cp", 32'(clock_p), 0);
    chk("t5_fall_busy", 32'(busy), 1);
    run_len(1'b0, n);
    chk("t5_low_len", 32'(n), 3);
    chk("t5_busy_after", 32'(busy), 1);

    // Async reset mid-high with a pending cfg: cfg lost, H back to 5.
    cfg_valid = 1'b1;
    cfg_half  = 24'd7;
    step();
    cfg_valid = 1'b0;
    chk("t6_pend_ready", 32'(cfg_ready), 0);
    chk("t6_pre_cp", 32'(clock_p), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_cp", 32'(clock_p), 0);
    chk("t6_rst_tick", 32'(tick), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_ready", 32'(cfg_ready), 1);
    chk("t6_rst_err", 32'(cfg_err), 0);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("t6_run_busy", 32'(busy), 1);
    run_len(1'b0, n);
    chk("t6_low_len", 32'(n), 5);
    run_len(1'b1, n);
    chk("t6_high_len", 32'(n), 5);
    chk("t6_ready", 32'(cfg_ready), 1);

    // Stop in low phase is immediate; then H=1 applied while idle.
    enable = 1'b0;
    step();
    chk("h1_idle_busy", 32'(busy), 0);
    chk("h1_idle_cp", 32'(clock_p), 0);
    cfg_valid = 1'b1;
    cfg_half  = 24'd1;
    step();
    cfg_valid = 1'b0;
    chk("h1_ready_low", 32'(cfg_ready), 0);
    step();
    chk("h1_ready_back", 32'(cfg_ready), 1);
    enable = 1'b1;
    step();
    chk("h1_s0_cp", 32'(clock_p), 0);
    step();
    chk("h1_s1_cp", 32'(clock_p), 1);
    chk("h1_s1_tick", 32'(tick), 1);
    step();
    chk("h1_s2_cp", 32'(clock_p), 0);
    chk("h1_s2_tick", 32'(tick), 0);
    step();
    chk("h1_s3_cp", 32'(clock_p), 1);
    chk("h1_s3_tick", 32'(tick), 1);
    enable = 1'b0;
    step();
    chk("h1_stop_cp", 32'(clock_p), 0);
    chk("h1_stop_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
